// File: rtl/cam_line_packer.sv
// cam_line_packer: packs camera bytes into 32-bit FIFO words, each line prefixed by a header word.
// Latency: header 1 cycle after byte 0; data word 1 cycle after its 4th byte; pad/checksum after line end.
// Backpressure: never stalls; a write meeting wr_full is dropped, the rest of the line is discarded, ovf_cnt counts it.
// Optional feature macro: LINE_CSUM_EN appends a per-line XOR checksum word after the last data/pad word.
module cam_line_packer #(
  parameter int unsigned IMG_W     = 1280,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        wr_full,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic [7:0]  frame_id,
  output logic [15:0] line_id,
  output logic        line_err,
  output logic [7:0]  ovf_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP, S_TAIL} state_t;

  localparam logic [15:0] W_IMG = 16'(IMG_W);

  state_t      r_state;
  logic [15:0] r_cnt;       // bytes seen so far in the current line (saturating)
  logic [23:0] r_lanes;     // lanes 0..2 of the word being assembled; unused lanes held at zero
  logic        r_pend;      // a write is due this cycle
  logic [31:0] r_word;      // word to write when r_pend is set
  logic [31:0] r_csum;      // XOR of all data/pad words formed in this line
  logic        r_csum_due;  // checksum word follows the pad word
  logic [7:0]  r_frame_id;
  logic [15:0] r_line_id;
  logic        r_line_err;
  logic [7:0]  r_ovf_cnt;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [23:0] w_lanes_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_word_nxt;
  logic [31:0] w_csum_nxt;
  logic        w_csum_due_nxt;
  logic [7:0]  w_frame_id_nxt;
  logic [15:0] w_line_id_nxt;
  logic        w_line_err_nxt;
  logic [7:0]  w_ovf_nxt;
  logic        w_ovf_hit;
  logic        w_partial;
  logic [15:0] w_cnt_inc;
  logic [7:0]  w_ovf_inc;

  // A due write is only lost in states that actually write; DROP never has one pending.
  assign w_ovf_hit = r_pend & wr_full & ((r_state == S_DATA) | (r_state == S_TAIL));
  assign w_partial = (r_cnt < W_IMG) && (r_cnt[1:0] != 2'd0);
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_ovf_inc = (r_ovf_cnt == 8'hFF) ? r_ovf_cnt : r_ovf_cnt + 8'd1;

  assign wr_en    = r_pend & ~wr_full;
  assign wr_data  = r_word;
  assign frame_id = r_frame_id;
  assign line_id  = r_line_id;
  assign line_err = r_line_err;
  assign ovf_cnt  = r_ovf_cnt;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_lanes    <= '0;
      r_pend     <= 1'b0;
      r_word     <= '0;
      r_csum     <= '0;
      r_csum_due <= 1'b0;
      r_frame_id <= '0;
      r_line_id  <= '0;
      r_line_err <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lanes    <= w_lanes_nxt;
      r_pend     <= w_pend_nxt;
      r_word     <= w_word_nxt;
      r_csum     <= w_csum_nxt;
      r_csum_due <= w_csum_due_nxt;
      r_frame_id <= w_frame_id_nxt;
      r_line_id  <= w_line_id_nxt;
      r_line_err <= w_line_err_nxt;
      r_ovf_cnt  <= w_ovf_nxt;
    end
  end

  // Next-state and next-datapath logic; frame_start overrides every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lanes_nxt    = r_lanes;
    w_pend_nxt     = 1'b0;
    w_word_nxt     = r_word;
    w_csum_nxt     = r_csum;
    w_csum_due_nxt = 1'b0;
    w_frame_id_nxt = r_frame_id;
    w_line_id_nxt  = r_line_id;
    w_line_err_nxt = 1'b0;
    w_ovf_nxt      = r_ovf_cnt;

    if (frame_start) begin
      w_frame_id_nxt = r_frame_id + 8'd1;
      w_line_id_nxt  = '0;
      w_cnt_nxt      = '0;
      w_lanes_nxt    = '0;
      w_state_nxt    = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (din_vld) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = 16'd1;
            w_lanes_nxt = {16'h0000, din};
            w_pend_nxt  = 1'b1;
            w_word_nxt  = {SYNC_BYTE, r_frame_id, r_line_id};
            w_csum_nxt  = '0;
          end
        end

        S_DATA: begin
          if (din_vld) begin
            w_cnt_nxt = w_cnt_inc;
            // Bytes past IMG_W are counted for line_err but never packed.
            if (r_cnt < W_IMG) begin
              case (r_cnt[1:0])
                2'd0: w_lanes_nxt[7:0]   = din;
                2'd1: w_lanes_nxt[15:8]  = din;
                2'd2: w_lanes_nxt[23:16] = din;
                2'd3: begin
                  w_pend_nxt  = 1'b1;
                  w_word_nxt  = {din, r_lanes};
                  w_csum_nxt  = r_csum ^ {din, r_lanes};
                  w_lanes_nxt = '0;
                end
                default: w_lanes_nxt = r_lanes;
              endcase
            end
          end else begin
            w_line_err_nxt = (r_cnt != W_IMG);
            w_line_id_nxt  = r_line_id + 16'd1;
            w_cnt_nxt      = '0;
            w_lanes_nxt    = '0;
            if (w_partial) begin
              w_pend_nxt  = 1'b1;
              w_word_nxt  = {8'h00, r_lanes};
              w_csum_nxt  = r_csum ^ {8'h00, r_lanes};
              w_state_nxt = S_TAIL;
`ifdef LINE_CSUM_EN
              w_csum_due_nxt = 1'b1;
`endif
            end else begin
`ifdef LINE_CSUM_EN
              // r_csum already covers the final word being written this cycle.
              w_pend_nxt  = 1'b1;
              w_word_nxt  = r_csum;
              w_state_nxt = S_TAIL;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          end
          // A lost write kills the rest of the line, including any pad/checksum.
          if (w_ovf_hit) begin
            w_pend_nxt     = 1'b0;
            w_csum_due_nxt = 1'b0;
            w_ovf_nxt      = w_ovf_inc;
            w_state_nxt    = din_vld ? S_DROP : S_IDLE;
          end
        end

        S_DROP: begin
          if (din_vld) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_line_err_nxt = (r_cnt != W_IMG);
            w_line_id_nxt  = r_line_id + 16'd1;
            w_cnt_nxt      = '0;
            w_lanes_nxt    = '0;
            w_state_nxt    = S_IDLE;
          end
        end

        S_TAIL: begin
          if (w_ovf_hit) begin
            w_ovf_nxt   = w_ovf_inc;
            w_state_nxt = S_IDLE;
          end else if (r_csum_due) begin
            w_pend_nxt = 1'b1;
            w_word_nxt = r_csum;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_line_packer.sv
// Testbench for cam_line_packer with IMG_W=8: directed scenarios plus randomized lines,
// checked against a line-level model of expected FIFO writes, line_err, line_id and ovf_cnt.
// Honours LINE_CSUM_EN when defined for the whole build.
module tb_cam_line_packer;

  localparam int          IMG_W = 8;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_vld = 1'b0;
  logic        wr_full = 1'b0;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [7:0]  frame_id;
  logic [15:0] line_id;
  logic        line_err;
  logic [7:0]  ovf_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [7:0]  m_frame = 8'h00;
  logic [15:0] m_line  = 16'h0000;
  int          m_ovf   = 0;

  logic [7:0]  lb [0:15];

  // Monitor state (written only by the monitor)
  logic [31:0] got_q[$];
  int          err_pulses = 0;
  int          full_viol  = 0;

  cam_line_packer #(.IMG_W(IMG_W), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .din(din), .din_vld(din_vld), .wr_full(wr_full),
    .wr_data(wr_data), .wr_en(wr_en), .frame_id(frame_id),
    .line_id(line_id), .line_err(line_err), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back(wr_data);
    if (line_err) err_pulses++;
    if (wr_en && wr_full) full_viol++;
  end

  // Drives one line of n bytes from lb[], with wr_full high only on relative cycle f
  // (cycle 0 = byte 0 sample), then 4 blank cycles, and checks the whole line.
  task automatic run_line(input string name, input int n, input int f);
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] w;
    logic [31:0] cs;
    int          nwords, hit, base, ebase, ngot;
    bit          pad;
    cs = '0;
    exp_q.push_back({SYNC, m_frame, m_line});
    due_q.push_back(1);
    nwords = ((n < IMG_W) ? n : IMG_W) / 4;
    for (int i = 0; i < nwords; i++) begin
      w = {lb[4*i+3], lb[4*i+2], lb[4*i+1], lb[4*i]};
      cs ^= w;
      exp_q.push_back(w);
      due_q.push_back(4*i + 4);
    end
    pad = (n < IMG_W) && (n % 4 != 0);
    if (pad) begin
      w = '0;
      for (int b = 0; b < n % 4; b++) w[8*b +: 8] = lb[4*nwords + b];
      cs ^= w;
      exp_q.push_back(w);
      due_q.push_back(n + 1);
    end
`ifdef LINE_CSUM_EN
    exp_q.push_back(cs);
    due_q.push_back(pad ? n + 2 : n + 1);
`endif
    hit = -1;
    for (int j = 0; j < due_q.size(); j++)
      if (hit < 0 && due_q[j] == f) hit = j;
    if (hit >= 0) begin
      while (exp_q.size() > hit) exp_q.pop_back();
      if (m_ovf < 255) m_ovf++;
    end

    base  = got_q.size();
    ebase = err_pulses;
    for (int c = 0; c < n + 4; c++) begin
      din_vld = (c < n);
      din     = (c < n) ? lb[c] : 8'h00;
      wr_full = (c == f);
      @(posedge clk); #1;
    end
    din_vld = 1'b0;
    din     = 8'h00;
    wr_full = 1'b0;
    m_line  = m_line + 16'd1;

    ngot = got_q.size() - base;
    tests++;
    if (ngot !== exp_q.size()) begin
      fails++;
      $display("FAIL %s write_count: got %0d want %0d", name, ngot, exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < ngot; j++) begin
      tests++;
      if (got_q[base + j] !== exp_q[j]) begin
        fails++;
        $display("FAIL %s word%0d: got %h want %h", name, j, got_q[base + j], exp_q[j]);
      end
    end
    tests++;
    if ((err_pulses - ebase) !== ((n != IMG_W) ? 1 : 0)) begin
      fails++;
      $display("FAIL %s line_err_pulses: got %0d want %0d", name, err_pulses - ebase, (n != IMG_W) ? 1 : 0);
    end
    tests++;
    if (ovf_cnt !== 8'(m_ovf)) begin
      fails++;
      $display("FAIL %s ovf_cnt: got %0d want %0d", name, ovf_cnt, m_ovf);
    end
    tests++;
    if (line_id !== m_line) begin
      fails++;
      $display("FAIL %s line_id: got %0d want %0d", name, line_id, m_line);
    end
  endtask

  task automatic pulse_frame_start(input string name);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_frame = m_frame + 8'd1;
    m_line  = 16'h0000;
    tests++;
    if (frame_id !== m_frame || line_id !== 16'h0000) begin
      fails++;
      $display("FAIL %s frame_start: got frame %0d line %0d want frame %0d line 0", name, frame_id, line_id, m_frame);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (wr_en !== 1'b0 || wr_data !== 32'h0 || frame_id !== 8'h0 || line_id !== 16'h0 ||
        line_err !== 1'b0 || ovf_cnt !== 8'h0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b dat=%h fr=%0d ln=%0d err=%b ovf=%0d want all 0",
               wr_en, wr_data, frame_id, line_id, line_err, ovf_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_line;
    pulse_frame_start("exact");
    for (int b = 0; b < 8; b++) lb[b] = 8'(b + 1);
    run_line("exact", 8, -1);
  endtask

  task automatic test_short_line;
    for (int b = 0; b < 6; b++) lb[b] = 8'(8'h11 + b);
    run_line("short", 6, -1);
  endtask

  task automatic test_long_line;
    for (int b = 0; b < 10; b++) lb[b] = 8'(8'h31 + b);
    run_line("long", 10, -1);
  endtask

  task automatic test_overflow;
    pulse_frame_start("ovf");
    for (int b = 0; b < 8; b++) lb[b] = 8'($urandom);
    run_line("ovf_data", 8, 4);
    for (int b = 0; b < 8; b++) lb[b] = 8'($urandom);
    run_line("after_ovf", 8, -1);
  endtask

  task automatic test_frame_abort;
    int base, ebase, ngot;
    logic [31:0] exp_hdr, exp_w0;
    for (int b = 0; b < 8; b++) lb[b] = 8'(8'h20 + b);
    exp_hdr = {SYNC, m_frame, m_line};
    exp_w0  = {lb[3], lb[2], lb[1], lb[0]};
    base  = got_q.size();
    ebase = err_pulses;
    for (int c = 0; c < 6; c++) begin
      din_vld     = 1'b1;
      din         = lb[c];
      frame_start = (c == 5);
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    din_vld     = 1'b0;
    din         = 8'h00;
    repeat (4) begin
      @(posedge clk); #1;
    end
    m_frame = m_frame + 8'd1;
    m_line  = 16'h0000;
    ngot = got_q.size() - base;
    tests++;
    if (ngot !== 2) begin
      fails++;
      $display("FAIL abort write_count: got %0d want 2", ngot);
    end
    if (ngot >= 2) begin
      tests++;
      if (got_q[base] !== exp_hdr || got_q[base + 1] !== exp_w0) begin
        fails++;
        $display("FAIL abort words: got %h %h want %h %h", got_q[base], got_q[base + 1], exp_hdr, exp_w0);
      end
    end
    tests++;
    if (err_pulses - ebase !== 0) begin
      fails++;
      $display("FAIL abort line_err: got %0d pulses want 0", err_pulses - ebase);
    end
    tests++;
    if (frame_id !== m_frame || line_id !== 16'h0000) begin
      fails++;
      $display("FAIL abort ids: got frame %0d line %0d want frame %0d line 0", frame_id, line_id, m_frame);
    end
    for (int b = 0; b < 8; b++) lb[b] = 8'($urandom);
    run_line("post_abort", 8, -1);
  endtask

  task automatic test_random;
    int n, f;
    for (int l = 0; l < 40; l++) begin
      if ($urandom_range(0, 5) == 0) pulse_frame_start("rand");
      n = $urandom_range(1, 12);
      f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n + 3) : -1;
      for (int b = 0; b < 16; b++) lb[b] = 8'($urandom);
      run_line("rand", n, f);
    end
  endtask

  task automatic test_reset_midline;
    for (int b = 0; b < 8; b++) lb[b] = 8'(b + 1);
    for (int c = 0; c < 4; c++) begin
      din_vld = 1'b1;
      din     = lb[c];
      @(posedge clk); #1;
    end
    // First data word is pending in this cycle; reset must kill it at once.
    rst_n = 1'b0;
    #1;
    tests++;
    if (wr_en !== 1'b0 || frame_id !== 8'h0 || line_id !== 16'h0 || ovf_cnt !== 8'h0 || line_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_midline: got en=%b fr=%0d ln=%0d ovf=%0d err=%b want all 0",
               wr_en, frame_id, line_id, ovf_cnt, line_err);
    end
    din_vld = 1'b0;
    din     = 8'h00;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_frame = 8'h00;
    m_line  = 16'h0000;
    m_ovf   = 0;
    run_line("post_reset", 8, -1);
  endtask

  task automatic test_flow_rule;
    tests++;
    if (full_viol !== 0) begin
      fails++;
      $display("FAIL wr_en_while_full: got %0d occurrences want 0", full_viol);
    end
  endtask

  initial begin
    test_reset;
    test_exact_line;
    test_short_line;
    test_long_line;
    test_overflow;
    test_frame_abort;
    test_random;
    test_reset_midline;
    test_flow_rule;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_line_packer.md
Name: cam_line_packer

Overview:
- Sits between the camera interface and the 8-in/32-out camera line FIFO, in the camera pixel-clock domain.
- Packs the camera byte stream into 32-bit words and prefixes every line with a header word (sync byte, frame id, line id), so the PC can reassemble frames from UDP payloads.
- Reports short/long lines and FIFO overflows. A line hit by overflow is dropped from that point on instead of being corrupted.

Parameters:
- IMG_W, 1280: expected bytes per line. Must be a multiple of 4 and ≥ 8.
- SYNC_BYTE, 8'hA5: marker placed in header bits [31:24].

Ports:
- clk  in  1  camera pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at frame start (vsync falling edge)
- din  in  8  camera byte
- din_vld  in  1  byte valid; high for the whole active line
- wr_full  in  1  FIFO full
- wr_data  out  32  FIFO write word; first byte of each group in [7:0]
- wr_en  out  1  FIFO write strobe
- frame_id  out  8  current frame number
- line_id  out  16  line number of the current/last line
- line_err  out  1  one-cycle pulse: line byte count ≠ IMG_W
- ovf_cnt  out  8  lines dropped due to wr_full; saturates at 255

Behaviour:
- Reset (asynchronous, rst_n low) clears all state; all outputs are 0; state goes to IDLE.
- States:
  - IDLE: wait for the first din_vld=1.
  - DATA: packing bytes.
  - DROP: discarding the rest of the line.
  - TAIL: pad or checksum write.
- Line start: the first din_vld=1 sample in IDLE is byte 0.
  - Next cycle: wr_en=1, wr_data={SYNC_BYTE, frame_id, line_id}.
  - Go to DATA.
  - If wr_full=1 in the header cycle: no write, ovf_cnt+1, go to DROP.
- Packing:
  - Byte k goes to lane k%4: lane 0 → [7:0] … lane 3 → [31:24].
  - When k%4==3: wr_en=1 the next cycle with the full word. Latency is 1 cycle from the 4th byte to the write.
  - The header and first data word never collide (header at byte0+1, word at byte3+1).
- Long line: bytes at k ≥ IMG_W are discarded (no write). line_err pulses at line end.
- Line end: the first din_vld=0 sample in DATA or DROP.
  - Bytes < IMG_W: line_err=1 for one cycle.
  - A partial word (1–3 bytes) is written in TAIL, unused lanes zero, one cycle after the end sample.
  - line_id increments by 1 (16-bit wrap) at every line end, including dropped lines.
  - Return to IDLE.
- Overflow:
  - If wr_full=1 on any cycle a write is due, the write is suppressed.
  - ovf_cnt increments once per line; state goes to DROP.
  - No further writes until the next line's header.
- frame_start:
  - frame_id+1 (8-bit wrap), line_id←0, byte count cleared.
  - From any state, the current line is aborted: no pad, no line_err, no line_id increment. Go to IDLE.
  - frame_start has priority over simultaneous din_vld/line-end events.
- Minimum horizontal blank is 2 cycles; 3 cycles with LINE_CSUM_EN.
- wr_en is never asserted while wr_full=1.

Optional Feature:
- LINE_CSUM_EN defined:
  - After the last data/pad word of a non-dropped line, one extra word is written on the next cycle: the 32-bit XOR of all data words of that line (header excluded).
  - If wr_full=1 at that point, the word is dropped and ovf_cnt increments.
- LINE_CSUM_EN undefined: no checksum word; TAIL is used only for the pad.

Test Plan:
- IMG_W=8, frame_start, then line bytes 01..08, din_vld low 4 cycles → writes A5_01_0000, 04030201, 08070605; line_err=0; line_id=1.
- IMG_W=8, 6-byte line 11..16 → header, 14131211, then pad 00001615; line_err pulse once.
- IMG_W=8, 10-byte line → header plus 2 data words only; line_err pulse; bytes 9–10 never written.
- wr_full asserted on the cycle word 1 is due → no further wr_en that line, ovf_cnt=1; next line (wr_full low) header line_id=1 written normally.
- frame_start pulsed at byte 5 of a line → no pad, no line_err; frame_id+1, line_id=0; next line header shows the new frame_id and line 0.
- LINE_CSUM_EN, IMG_W=8, bytes 01..08 → 4th write = 0C040404 (04030201 ^ 08070605); rst_n low mid-line → wr_en=0 and all counters 0 immediately.
